// File: rtl/base_target.sv
// Stationary defended object: per-frame bullet collision, HP tracking with blink/dead states, sprite addressing.
// Optional hit-point regeneration is enabled by defining BASE_REGEN_EN.
module base_target #(
   parameter int X_POS        = 320,
   parameter int Y_POS        = 416,
   parameter int SIZE         = 32,
   parameter int NUM_BULLETS  = 4,
   parameter int BULLET_SIZE  = 4,
   parameter int HIT_POINTS   = 3,
   parameter int FLASH_FRAMES = 30,
   parameter int REGEN_FRAMES = 600,
   localparam int CW          = $clog2(SIZE),
   localparam int HPW         = $clog2(HIT_POINTS + 1)
) (
   input  logic                      clk_50MHz,
   input  logic                      reset,
   input  logic [9:0]                x,
   input  logic [9:0]                y,
   input  logic                      refresh_tick,
   input  logic [10*NUM_BULLETS-1:0] bullet_x,
   input  logic [10*NUM_BULLETS-1:0] bullet_y,
   input  logic [NUM_BULLETS-1:0]    bullet_valid,
   output logic [NUM_BULLETS-1:0]    hit_ack,
   output logic [CW-1:0]             rom_row,
   output logic [CW-1:0]             rom_col,
   output logic                      base_on,
   output logic [HPW-1:0]            hp,
   output logic                      flashing,
   output logic                      destroyed
);

   // Counter must be at least 3 bits wide because bit 2 drives the blink.
   localparam int FCW = ($clog2(FLASH_FRAMES) < 3) ? 3 : $clog2(FLASH_FRAMES);

   localparam logic [10:0] XL = 11'(X_POS);
   localparam logic [10:0] XH = 11'(X_POS + SIZE);
   localparam logic [10:0] YL = 11'(Y_POS);
   localparam logic [10:0] YH = 11'(Y_POS + SIZE);
   localparam logic [10:0] BS = 11'(BULLET_SIZE);

   typedef enum logic [1:0] {ST_ALIVE, ST_FLASH, ST_DEAD} state_t;

   state_t                 r_state, w_state_nxt;
   logic [HPW-1:0]         r_hp, w_hp_nxt;
   logic [FCW-1:0]         r_flash_cnt, w_flash_nxt;
   logic [NUM_BULLETS-1:0] r_hit_ack;
   logic                   r_base_on;
   logic [NUM_BULLETS-1:0] w_hit;
   logic                   w_any_hit;
   logic                   w_inside;
   logic                   w_visible;

`ifdef BASE_REGEN_EN
   localparam int RCW = (REGEN_FRAMES > 1) ? $clog2(REGEN_FRAMES) : 1;
   logic [RCW-1:0]         r_regen_cnt, w_regen_nxt;
`endif

   // 11-bit comparisons so bx + BULLET_SIZE never wraps near the screen edge.
   for (genvar i = 0; i < NUM_BULLETS; i++) begin : g_hit
      logic [10:0] w_bx, w_by;
      assign w_bx     = {1'b0, bullet_x[10*i +: 10]};
      assign w_by     = {1'b0, bullet_y[10*i +: 10]};
      assign w_hit[i] = refresh_tick && bullet_valid[i]
                        && (w_bx + BS > XL) && (w_bx < XH)
                        && (w_by + BS > YL) && (w_by < YH);
   end

   assign w_any_hit = |w_hit;

   always_comb begin
      w_state_nxt = r_state;
      w_hp_nxt    = r_hp;
      w_flash_nxt = r_flash_cnt;
`ifdef BASE_REGEN_EN
      w_regen_nxt = r_regen_cnt;
`endif
      if (refresh_tick) begin
         case (r_state)
            ST_ALIVE: begin
               if (w_any_hit) begin
`ifdef BASE_REGEN_EN
                  w_regen_nxt = '0;
`endif
                  if (r_hp > HPW'(1)) begin
                     w_hp_nxt    = r_hp - HPW'(1);
                     w_state_nxt = ST_FLASH;
                     w_flash_nxt = FCW'(FLASH_FRAMES - 1);
                  end else begin
                     w_hp_nxt    = '0;
                     w_state_nxt = ST_DEAD;
                  end
               end
`ifdef BASE_REGEN_EN
               else if (r_hp < HPW'(HIT_POINTS)) begin
                  if (r_regen_cnt == RCW'(REGEN_FRAMES - 1)) begin
                     w_hp_nxt    = r_hp + HPW'(1);
                     w_regen_nxt = '0;
                  end else begin
                     w_regen_nxt = r_regen_cnt + RCW'(1);
                  end
               end
`endif
            end
            ST_FLASH: begin
               if (r_flash_cnt == '0) w_state_nxt = ST_ALIVE;
               else                   w_flash_nxt = r_flash_cnt - FCW'(1);
            end
            default: ;
         endcase
      end
   end

   assign w_inside  = ({1'b0, x} >= XL) && ({1'b0, x} < XH)
                   && ({1'b0, y} >= YL) && ({1'b0, y} < YH);
   assign w_visible = (r_state != ST_FLASH) || !r_flash_cnt[2];

   always_ff @(posedge clk_50MHz) begin
      if (!reset) begin
         r_state     <= ST_ALIVE;
         r_hp        <= HPW'(HIT_POINTS);
         r_flash_cnt <= '0;
         r_hit_ack   <= '0;
         r_base_on   <= 1'b0;
`ifdef BASE_REGEN_EN
         r_regen_cnt <= '0;
`endif
      end else begin
         r_state     <= w_state_nxt;
         r_hp        <= w_hp_nxt;
         r_flash_cnt <= w_flash_nxt;
         r_hit_ack   <= w_hit;
         r_base_on   <= w_inside && w_visible;
`ifdef BASE_REGEN_EN
         r_regen_cnt <= w_regen_nxt;
`endif
      end
   end

   // Row/col addresses are combinational so ROM data lines up with registered base_on.
   assign rom_row   = CW'(y - 10'(Y_POS));
   assign rom_col   = CW'(x - 10'(X_POS));
   assign hit_ack   = r_hit_ack;
   assign base_on   = r_base_on;
   assign hp        = r_hp;
   assign flashing  = (r_state == ST_FLASH);
   assign destroyed = (r_state == ST_DEAD);

endmodule

// File: tb/tb_base_target.sv
// Directed bench for base_target: collision edges, FLASH/DEAD sequencing, visibility and optional regen.
module tb_base_target;

   logic        clk_50MHz = 1'b0;
   logic        reset;
   logic [9:0]  x, y;
   logic        refresh_tick;
   logic [39:0] bullet_x, bullet_y;
   logic [3:0]  bullet_valid;
   logic [3:0]  hit_ack;
   logic [4:0]  rom_row, rom_col;
   logic        base_on;
   logic [1:0]  hp;
   logic        flashing, destroyed;

   int checks = 0;
   int errors = 0;

   base_target #(.REGEN_FRAMES(8)) dut (
      .clk_50MHz    (clk_50MHz),
      .reset        (reset),
      .x            (x),
      .y            (y),
      .refresh_tick (refresh_tick),
      .bullet_x     (bullet_x),
      .bullet_y     (bullet_y),
      .bullet_valid (bullet_valid),
      .hit_ack      (hit_ack),
      .rom_row      (rom_row),
      .rom_col      (rom_col),
      .base_on      (base_on),
      .hp           (hp),
      .flashing     (flashing),
      .destroyed    (destroyed)
   );

   always #5 clk_50MHz = ~clk_50MHz;

   task automatic check_eq(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One refresh tick with the given bullets; returns #1 after the edge that registers the result.
   task automatic tick(input logic [3:0] v, input logic [39:0] bx, input logic [39:0] by);
      refresh_tick = 1'b1;
      bullet_valid = v;
      bullet_x     = bx;
      bullet_y     = by;
      @(posedge clk_50MHz);
      #1;
      refresh_tick = 1'b0;
      bullet_valid = '0;
      bullet_x     = '0;
      bullet_y     = '0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         tick(4'b0000, 40'd0, 40'd0);
         @(posedge clk_50MHz);
         #1;
      end
   endtask

   task automatic cyc();
      @(posedge clk_50MHz);
      #1;
   endtask

   initial begin
      reset        = 1'b0;
      x            = '0;
      y            = '0;
      refresh_tick = 1'b0;
      bullet_x     = '0;
      bullet_y     = '0;
      bullet_valid = '0;
      repeat (2) cyc();
      check_eq("rst_hp", hp, 3);
      check_eq("rst_ack", hit_ack, 0);
      check_eq("rst_base_on", base_on, 0);
      check_eq("rst_flash", flashing, 0);
      check_eq("rst_dead", destroyed, 0);
      reset = 1'b1;

      idle(3);
      check_eq("idle_hp", hp, 3);
      check_eq("idle_ack", hit_ack, 0);

      // Visibility window and ROM addressing
      x = 10'd320; y = 10'd416; cyc();
      check_eq("on_corner", base_on, 1);
      x = 10'd352; cyc();
      check_eq("off_right", base_on, 0);
      x = 10'd351; y = 10'd447; cyc();
      check_eq("on_far_corner", base_on, 1);
      y = 10'd448; cyc();
      check_eq("off_below", base_on, 0);
      x = 10'd319; y = 10'd420; cyc();
      check_eq("off_left", base_on, 0);
      x = 10'd330; y = 10'd420; #1;
      check_eq("rom_col", rom_col, 10);
      check_eq("rom_row", rom_row, 4);

      // Near misses in y while ALIVE
      tick(4'b0001, {30'd0, 10'd330}, {30'd0, 10'd412});
      check_eq("miss_y_top_ack", hit_ack, 0);
      cyc();
      tick(4'b0001, {30'd0, 10'd330}, {30'd0, 10'd448});
      check_eq("miss_y_bot_ack", hit_ack, 0);
      check_eq("miss_hp", hp, 3);
      cyc();

      // First damaging hit on channel 0
      tick(4'b0001, {30'd0, 10'd330}, {30'd0, 10'd420});
      check_eq("hit1_ack", hit_ack, 4'b0001);
      check_eq("hit1_hp", hp, 2);
      check_eq("hit1_flash", flashing, 1);
      x = 10'd320; y = 10'd416;
      cyc();
      check_eq("hit1_ack_gone", hit_ack, 0);
      cyc();
      check_eq("blink_hidden", base_on, 0);

      // Hits during FLASH: acked, no damage; x edge at 317 vs 316
      tick(4'b0100, {10'd0, 10'd317, 20'd0}, {10'd0, 10'd420, 20'd0});
      check_eq("flash_hit_ack", hit_ack, 4'b0100);
      check_eq("flash_hit_hp", hp, 2);
      cyc();
      tick(4'b0100, {10'd0, 10'd316, 20'd0}, {10'd0, 10'd420, 20'd0});
      check_eq("edge316_ack", hit_ack, 0);
      cyc();
      check_eq("blink_shown", base_on, 1);
      idle(27);
      check_eq("flash_still", flashing, 1);
      idle(1);
      check_eq("flash_done", flashing, 0);
      check_eq("flash_done_hp", hp, 2);

      // Two channels on one tick: both acked, one HP lost
      tick(4'b1010, {10'd340, 10'd0, 10'd330, 10'd0}, {10'd430, 10'd0, 10'd440, 10'd0});
      check_eq("multi_ack", hit_ack, 4'b1010);
      check_eq("multi_hp", hp, 1);
      idle(30);
      check_eq("multi_flash_done", flashing, 0);

      // Final hit destroys; DEAD still acks and stays visible
      tick(4'b0001, {30'd0, 10'd330}, {30'd0, 10'd420});
      check_eq("kill_hp", hp, 0);
      check_eq("kill_dead", destroyed, 1);
      check_eq("kill_flash", flashing, 0);
      cyc();
      check_eq("dead_visible", base_on, 1);
      tick(4'b0001, {30'd0, 10'd330}, {30'd0, 10'd420});
      check_eq("dead_ack", hit_ack, 4'b0001);
      check_eq("dead_hp", hp, 0);
      idle(40);
      check_eq("dead_sticky", destroyed, 1);

      reset = 1'b0; cyc(); reset = 1'b1;
      check_eq("rerst_hp", hp, 3);
      check_eq("rerst_dead", destroyed, 0);

      tick(4'b0001, {30'd0, 10'd330}, {30'd0, 10'd420});
      check_eq("r_hit_hp", hp, 2);
      idle(30);
      check_eq("r_alive", flashing, 0);
`ifdef BASE_REGEN_EN
      idle(7);
      check_eq("regen_pre", hp, 2);
      idle(1);
      check_eq("regen_up", hp, 3);
      tick(4'b0001, {30'd0, 10'd330}, {30'd0, 10'd420});
      check_eq("regen_hit2_hp", hp, 2);
      idle(30);
      idle(5);
      tick(4'b0001, {30'd0, 10'd330}, {30'd0, 10'd420});
      check_eq("regen_hit3_hp", hp, 1);
      idle(30);
      idle(7);
      check_eq("regen_restart_pre", hp, 1);
      idle(1);
      check_eq("regen_restart_up", hp, 2);
`else
      idle(20);
      check_eq("no_regen_hp", hp, 2);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
